// File: rtl/mux_rr_nin_nbit.sv
// Registered M-input N-bit mux: fixed select via s, or round-robin across valid channels.
// Latency: one cycle from a transfer (v[k] && rdy[k]) to zv.
// Backpressure: rdy is withheld while the output register is full and zr is low.
module mux_rr_nin_nbit #(
    parameter int N  = 2,
    parameter int M  = 4,
    parameter int SW = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [M*N-1:0]    x,
    input  logic [M-1:0]      v,
    output logic [M-1:0]      rdy,
    input  logic              mode,
    input  logic [SW-1:0]     s,
    output logic [N-1:0]      z,
    output logic [SW-1:0]     zch,
    output logic              zv,
    input  logic              zr
);

    logic [N-1:0]  z_q,   z_d;
    logic [SW-1:0] zch_q, zch_d;
    logic          zv_q,  zv_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          ld;
    logic          grant;
    logic [SW-1:0] gidx;
    logic [N-1:0]  gdat;
    logic [SW:0]   sum;
    logic [SW-1:0] cidx;

    assign ld = !zv_q || zr;

    // One extra bit in sum keeps ptr+i from wrapping before the mod-M correction.
    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        sum   = '0;
        cidx  = '0;
        if (mode) begin
            for (int i = 0; i < M; i++) begin
                sum = {1'b0, ptr_q} + (SW+1)'(i);
                if (sum >= (SW+1)'(M)) begin
                    sum = sum - (SW+1)'(M);
                end
                cidx = sum[SW-1:0];
                if (!grant && v[cidx]) begin
                    grant = 1'b1;
                    gidx  = cidx;
                end
            end
        end else if (int'(s) < M) begin
            if (v[s]) begin
                grant = 1'b1;
                gidx  = s;
            end
        end
    end

    always_comb begin
        gdat = '0;
        rdy  = '0;
        for (int k = 0; k < M; k++) begin
            if (gidx == SW'(k)) begin
                gdat   = x[k*N +: N];
                rdy[k] = rst_n && ld && grant;
            end
        end
    end

    always_comb begin
        z_d   = z_q;
        zch_d = zch_q;
        zv_d  = zv_q;
        ptr_d = ptr_q;
        if (ld) begin
            if (grant) begin
                z_d   = gdat;
                zch_d = gidx;
                zv_d  = 1'b1;
                if (mode) begin
                    ptr_d = (int'(gidx) == M-1) ? '0 : gidx + SW'(1);
                end
            end else begin
                zv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= '0;
            zch_q <= '0;
            zv_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            z_q   <= z_d;
            zch_q <= zch_d;
            zv_q  <= zv_d;
            ptr_q <= ptr_d;
        end
    end

    assign z   = z_q;
    assign zch = zch_q;
    assign zv  = zv_q;

endmodule

// File: doc/mux_rr_nin_nbit.md
Name: mux_rr_nin_nbit

Overview:
Registered, parametrised M-input, N-bit multiplexer with per-channel valid/ready handshakes and a one-entry output register. It supports two selection modes:
- fixed select, the classic mux behaviour driven by s;
- round-robin arbitration across all requesting channels.

It sits between several N-bit producers and a single consumer, replacing the combinational 2-input mux wherever back-pressure or fair sharing is needed.

Parameters:
- N, 2, data width of each channel and of z.
- M, 4, number of input channels; M >= 2.
- SW, $clog2(M), width of s and zch (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x  in  M*N  flattened channel data; channel k occupies bits [k*N +: N].
- v  in  M  per-channel valid.
- rdy  out  M  per-channel accept, one-hot or zero, combinational.
- mode  in  1  0 = fixed select via s; 1 = round-robin.
- s  in  SW  channel select, used only when mode = 0.
- z  out  N  registered output data.
- zch  out  SW  index of the channel that produced z.
- zv  out  1  output valid.
- zr  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, while rst_n = 0):
  - z = 0, zch = 0, zv = 0;
  - round-robin pointer ptr = 0;
  - rdy = 0 regardless of inputs.
- Load enable: ld = !zv || zr. The output register accepts new data only when it is empty or being drained in the same cycle.
- Grant g, combinational:
  - mode 0: grant channel s iff v[s] = 1. If s >= M (M not a power of 2), there is no grant.
  - mode 1: grant the first k with v[k] = 1, scanning ptr, ptr+1, ..., M-1, 0, ..., ptr-1 (mod M). No v bit set means no grant.
- rdy[g] = ld && grant. All other rdy bits are 0. A channel transfer occurs when v[k] && rdy[k].
- On a rising edge with ld = 1:
  - if there is a grant: z <= x[g], zch <= g, zv <= 1;
  - if there is no grant: zv <= 0; z and zch hold their last values.
- On a rising edge with ld = 0 (zv = 1, zr = 0): z, zch and zv hold. No rdy is asserted. Inputs must keep v and data stable (producer rule).
- ptr update:
  - ptr <= (g+1) mod M only on a transfer in mode 1;
  - ptr holds in mode 0, with no transfer, and while stalled.
- Latency is one cycle from transfer to zv. Throughput is one word per cycle while zr = 1 and a grant exists.
- Simultaneous events:
  - Drain and load in the same cycle (zv = 1, zr = 1, grant) is a back-to-back transfer; zv stays 1.
  - A mode change takes effect on the next grant evaluation. ptr is not reset by a mode change.
  - mode or s changing while stalled has no effect until ld = 1.
- Reset mid-operation: the output word is discarded (zv -> 0 immediately, asynchronously) and ptr returns to 0. After deassertion, the first grant in mode 1 starts from channel 0.
- Fairness: in mode 1 with all M channels continuously valid and zr = 1, grants cycle 0, 1, ..., M-1, 0, ... Each channel gets exactly one grant per M transfers.

Test Plan (N = 2, M = 4):
1. Reset check: assert rst_n = 0 mid-stream with zv = 1 -> zv, z, zch, rdy all 0 immediately. After release with mode = 1 and v = 4'b1111, first zch = 0.
2. Fixed select sweep: mode = 0, zr = 1, v = 4'b1111, x = {2'b11, 2'b10, 2'b01, 2'b00}, s stepped 0..3 each cycle -> z = 00, 01, 10, 11 one cycle after each s. rdy = one-hot of s.
3. Fixed select, unselected channel idle: mode = 0, s = 2, v = 4'b1011 -> rdy = 0. zv drops to 0 after the current word drains.
4. Round-robin fairness: mode = 1, zr = 1, v = 4'b1111 for 8 cycles -> zch sequence 0, 1, 2, 3, 0, 1, 2, 3. Then v = 4'b1010 -> zch alternates 1, 3, 1, 3.
5. Back-pressure: mode = 1, v = 4'b0100, x[2] = 2'b10, zr = 0 for 3 cycles -> zv = 1, z = 10, zch = 2 held; rdy = 0 during stall. zr = 1 -> next word loads the same cycle, with no gap and no duplicate.
6. Empty drain and mode switch: zv = 1, zr = 1, v = 0 -> zv = 0 next cycle. Then switch mode 1 -> 0 with ptr = 3, s = 1, v = 4'b0010 -> zch = 1. Switch back to mode 1 with v = 4'b1111 -> next zch = 3 (ptr preserved).
